// File: rtl/draw_rect_engine_if.sv
// Request/pixel bus between a paint client and draw_rect_engine.
// The client drives the request fields and ready; the engine drives the pixel stream and status.
interface draw_rect_engine_if #(
  parameter int XW = 8,
  parameter int YW = 8,
  parameter int SW = 4,
  parameter int CW = 3
);
  logic          start;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic [SW-1:0] size_x;
  logic [SW-1:0] size_y;
  logic          mode;
  logic [CW-1:0] colour_in;
  logic          ready;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic [CW-1:0] out_colour;
  logic          plot;
  logic          busy;
  logic          done;

  modport master (
    output start, x0, y0, size_x, size_y, mode, colour_in, ready,
    input  out_x, out_y, out_colour, plot, busy, done
  );

  modport slave (
    input  start, x0, y0, size_x, size_y, mode, colour_in, ready,
    output out_x, out_y, out_colour, plot, busy, done
  );
endinterface

// File: rtl/draw_rect_engine.sv
// Rectangle rasteriser: latches a request, scans one position per cycle in raster order,
// clips to the screen, suppresses outline interiors, and holds on plot && !ready.
module draw_rect_engine #(
  parameter int XW       = 8,
  parameter int YW       = 8,
  parameter int SW       = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int CW       = 3
) (
  input  logic              clk,
  input  logic              reset,
  draw_rect_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [XW:0] ScrW = (XW+1)'(SCREEN_W);
  localparam logic [YW:0] ScrH = (YW+1)'(SCREEN_H);

  state_t        state_q, state_d;
  logic [SW-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [XW-1:0] x0_q, x0_d;
  logic [YW-1:0] y0_q, y0_d;
  logic [SW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] colour_q, colour_d;

  logic [XW:0] sum_x;
  logic [YW:0] sum_y;
  logic        clipped, interior, plot, advance, last_x, last_pos;

  // Sums carry one extra bit so positions past the coordinate range still clip.
  assign sum_x    = {1'b0, x0_q} + {{(XW+1-SW){1'b0}}, dx_q};
  assign sum_y    = {1'b0, y0_q} + {{(YW+1-SW){1'b0}}, dy_q};
  assign clipped  = (sum_x >= ScrW) || (sum_y >= ScrH);
  assign interior = !((dx_q == '0) || (dx_q == sx_q) || (dy_q == '0) || (dy_q == sy_q));
  assign plot     = (state_q == SCAN) && !clipped && !(mode_q && interior);
  assign advance  = (state_q == SCAN) && (!plot || bus.ready);
  assign last_x   = (dx_q == sx_q);
  assign last_pos = last_x && (dy_q == sy_q);

  assign bus.out_x      = sum_x[XW-1:0];
  assign bus.out_y      = sum_y[YW-1:0];
  assign bus.out_colour = colour_q;
  assign bus.plot       = plot;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    mode_d   = mode_q;
    colour_d = colour_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = SCAN;
          dx_d     = '0;
          dy_d     = '0;
          x0_d     = bus.x0;
          y0_d     = bus.y0;
          sx_d     = bus.size_x;
          sy_d     = bus.size_y;
          mode_d   = bus.mode;
          colour_d = bus.colour_in;
        end
      end
      SCAN: begin
        if (advance) begin
          if (last_pos) begin
            state_d = DONE;
          end else if (last_x) begin
            dx_d = '0;
            dy_d = dy_q + SW'(1);
          end else begin
            dx_d = dx_q + SW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      dx_q     <= '0;
      dy_q     <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      mode_q   <= 1'b0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      mode_q   <= mode_d;
      colour_q <= colour_d;
    end
  end

endmodule
